// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared constants for the Common Data Bus arbitration logic.
//   CDB_TAG_WIDTH  : reservation-station tag width
//   CDB_DATA_WIDTH : functional-unit result width
//   FU_*           : request index of each functional unit on the CDB
//   NUM_FU         : number of functional units sharing the CDB
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

   localparam int CDB_TAG_WIDTH  = 6;
   localparam int CDB_DATA_WIDTH = 32;

   localparam int FU_ALU = 0;
   localparam int FU_MUL = 1;
   localparam int FU_DIV = 2;
   localparam int FU_LSU = 3;
   localparam int NUM_FU = 4;

endpackage : cdb_arbiter_pkg

// File: rtl/cdb_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational rotating-priority picker. Scans the request vector starting
// at ptr_i, wrapping after NUM_REQ-1, and selects the first set bit.
//   req_i   : request vector
//   ptr_i   : index with highest priority (must be < NUM_REQ)
//   grant_o : one-hot grant, all zero when no request is set
//   idx_o   : encoded index of the granted request (0 when none)
// -----------------------------------------------------------------------------
module rr_priority_picker #(
   parameter int NUM_REQ   = 4,
   parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [IDX_WIDTH-1:0] ptr_i,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic [IDX_WIDTH-1:0] idx_o
);

   logic                 found;
   logic [IDX_WIDTH-1:0] cand;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = ptr_i;
      // NOTE: blocking assignments here model a sequential scan within one
      // combinational evaluation; cand and found carry between iterations.
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_i[cand]) begin
            grant_o[cand] = 1'b1;
            idx_o         = cand;
            found         = 1'b1;
         end
         // Explicit compare so non-power-of-two NUM_REQ wraps correctly.
         cand = (cand == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      end
   end

endmodule : rr_priority_picker

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter sharing the Common Data Bus among functional units.
// One unit is granted per cycle (combinational grant) and its result is
// broadcast on registered cdb_* outputs one cycle later.
//   clk        : clock, all state on rising edge
//   reset      : synchronous active-low reset
//   req_valid  : per-unit result pending
//   req_tag    : per-unit tags, unit i at [i*TAG_WIDTH +: TAG_WIDTH]
//   req_data   : per-unit results, unit i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_grant  : one-hot grant, result of unit i accepted this cycle
//   flush      : suppress arbitration this cycle
//   cdb_valid  : registered broadcast valid
//   cdb_tag    : registered broadcast tag
//   cdb_data   : registered broadcast data
//   cdb_src    : index of the unit that produced the broadcast
// -----------------------------------------------------------------------------
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = NUM_FU,
   parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
   parameter int DATA_WIDTH = CDB_DATA_WIDTH,
   parameter int SRC_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_grant,
   input  logic                          flush,
   output logic                          cdb_valid,
   output logic [TAG_WIDTH-1:0]          cdb_tag,
   output logic [DATA_WIDTH-1:0]         cdb_data,
   output logic [SRC_WIDTH-1:0]          cdb_src
);

   logic [NUM_REQ-1:0]    pick_req;
   logic [NUM_REQ-1:0]    pick_grant;
   logic [SRC_WIDTH-1:0]  pick_idx;

   logic [SRC_WIDTH-1:0]  ptr_q,       ptr_d;
   logic                  cdb_valid_q, cdb_valid_d;
   logic [TAG_WIDTH-1:0]  cdb_tag_q,   cdb_tag_d;
   logic [DATA_WIDTH-1:0] cdb_data_q,  cdb_data_d;
   logic [SRC_WIDTH-1:0]  cdb_src_q,   cdb_src_d;

   // Reset and flush both mask requests ahead of the picker, so the grant
   // is forced low combinationally in either case.
   always_comb begin
      pick_req = (reset && !flush) ? req_valid : '0;
   end

   rr_priority_picker #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (SRC_WIDTH)
   ) u_picker (
      .req_i   (pick_req),
      .ptr_i   (ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx)
   );

   assign req_grant = pick_grant;

   always_comb begin
      ptr_d       = ptr_q;
      cdb_valid_d = |pick_grant;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      cdb_src_d   = cdb_src_q;
      if (|pick_grant) begin
         ptr_d      = (pick_idx == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
         cdb_tag_d  = req_tag[pick_idx*TAG_WIDTH +: TAG_WIDTH];
         cdb_data_d = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
         cdb_src_d  = pick_idx;
      end
   end

   // NOTE: reset is synchronous, so it appears only inside the clocked
   // branch and not in the sensitivity list; payload registers are cleared
   // too so the bus reads zero after reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      if (!reset) begin
         ptr_q       <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_src   = cdb_src_q;

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Scoreboard bench for cdb_arbiter. Each cycle a reference round-robin model
// predicts the grant and the broadcast that must follow; the broadcast is
// queued and popped after the clock edge for comparison.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int TW = 6;
   localparam int DW = 32;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*TW-1:0] req_tag = '0;
   logic [N*DW-1:0] req_data = '0;
   logic            flush = 1'b0;
   logic [N-1:0]    req_grant;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;
   logic [SW-1:0]   cdb_src;

   cdb_arbiter #(
      .NUM_REQ    (N),
      .TAG_WIDTH  (TW),
      .DATA_WIDTH (DW),
      .SRC_WIDTH  (SW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .req_grant (req_grant),
      .flush     (flush),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          valid;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      logic [SW-1:0] src;
   } bcast_t;

   bcast_t       sb_q[$];
   int           total = 0;
   int           bad   = 0;
   int           m_ptr = 0;
   bcast_t       m_cdb = '0;
   logic [N-1:0] obs_grant;
   int           wait_cnt[N];
   int           max_wait = 0;

   task automatic set_unit(input int i, input logic [TW-1:0] tag, input logic [DW-1:0] data);
      req_tag[i*TW +: TW]  = tag;
      req_data[i*DW +: DW] = data;
   endtask

   // One clock cycle: predict and check the grant mid-cycle, queue the
   // predicted broadcast, then compare it just after the rising edge.
   task automatic cycle(input string name);
      logic [N-1:0] g;
      int           win;
      bcast_t       exp_b;
      bcast_t       got_b;
      @(negedge clk);
      g   = '0;
      win = -1;
      if (reset && !flush) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (win < 0 && req_valid[i]) win = i;
         end
      end
      if (win >= 0) g[win] = 1'b1;
      total++;
      if (req_grant !== g) begin
         bad++;
         $display("FAIL %s grant: got %b expected %b", name, req_grant, g);
      end
      obs_grant = req_grant;
      if (reset && !flush) begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && !req_grant[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
         end
      end
      if (!reset) begin
         m_ptr = 0;
         m_cdb = '0;
      end else begin
         m_cdb.valid = (win >= 0);
         if (win >= 0) begin
            m_cdb.tag  = req_tag[win*TW +: TW];
            m_cdb.data = req_data[win*DW +: DW];
            m_cdb.src  = SW'(win);
            m_ptr      = (win + 1) % N;
         end
      end
      sb_q.push_back(m_cdb);
      @(posedge clk);
      #1;
      total++;
      if (sb_q.size() == 0) begin
         bad++;
         $display("FAIL %s scoreboard empty", name);
      end else begin
         exp_b = sb_q.pop_front();
         got_b = {cdb_valid, cdb_tag, cdb_data, cdb_src};
         if (got_b !== exp_b) begin
            bad++;
            $display("FAIL %s cdb: got v=%b tag=%h data=%h src=%0d expected v=%b tag=%h data=%h src=%0d",
                     name, cdb_valid, cdb_tag, cdb_data, cdb_src,
                     exp_b.valid, exp_b.tag, exp_b.data, exp_b.src);
         end
      end
   endtask

   task automatic expect_grant(input string name, input logic [N-1:0] want);
      total++;
      if (obs_grant !== want) begin
         bad++;
         $display("FAIL %s: grant %b expected %b", name, obs_grant, want);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      flush     = 1'b0;
      req_valid = '0;
      cycle("reset_pulse");
      reset = 1'b1;
   endtask

   task automatic load_default_payloads();
      set_unit(FU_ALU, 6'h00, 32'h1111_0000);  // tag 0 is a legal tag
      set_unit(FU_MUL, 6'h0B, 32'h2222_0001);
      set_unit(FU_DIV, 6'h1C, 32'h3333_0002);
      set_unit(FU_LSU, 6'h3F, 32'h4444_0003);
   endtask

   task automatic test_reset();
      load_default_payloads();
      set_unit(FU_ALU, 6'h07, 32'hA5A5_0000);
      reset     = 1'b0;
      req_valid = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         cycle("reset_hold");
         expect_grant("reset_hold_grant", 4'b0000);
      end
      reset = 1'b1;
      cycle("reset_release");
      expect_grant("reset_release_grant", 4'b0001);
      req_valid = '0;
      cycle("reset_release_idle");
   endtask

   task automatic test_single();
      do_reset();
      set_unit(FU_DIV, 6'h15, 32'hDEAD_BEEF);
      req_valid = 4'b0100;
      for (int c = 0; c < 4; c++) begin
         cycle("single");
         expect_grant("single_grant", 4'b0100);
      end
      req_valid = '0;
      cycle("single_idle");
   endtask

   task automatic test_contention();
      int order[6] = '{0, 1, 2, 3, 0, 1};
      load_default_payloads();
      do_reset();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      max_wait  = 0;
      req_valid = 4'b1111;
      for (int c = 0; c < 6; c++) begin
         cycle("contention");
         expect_grant("contention_order", N'(1) << order[c]);
      end
      req_valid = '0;
      cycle("contention_idle");
      total++;
      if (max_wait > N - 1) begin
         bad++;
         $display("FAIL contention_fairness: max wait %0d expected at most %0d", max_wait, N - 1);
      end
   endtask

   task automatic test_wrap();
      load_default_payloads();
      do_reset();
      req_valid = 4'b0100;
      cycle("wrap_setup");
      expect_grant("wrap_setup_grant", 4'b0100);
      req_valid = 4'b0011;
      cycle("wrap_a");
      expect_grant("wrap_a_grant", 4'b0001);
      set_unit(FU_ALU, 6'h21, 32'h5555_AAAA);
      req_valid = 4'b1011;
      cycle("wrap_b");
      expect_grant("wrap_b_grant", 4'b0010);
      req_valid = 4'b1001;
      cycle("wrap_c");
      expect_grant("wrap_c_grant", 4'b1000);
      req_valid = 4'b0001;
      cycle("wrap_d");
      expect_grant("wrap_d_grant", 4'b0001);
      req_valid = '0;
      cycle("wrap_idle");
   endtask

   task automatic test_flush();
      load_default_payloads();
      do_reset();
      req_valid = 4'b0010;
      flush     = 1'b1;
      cycle("flush_on");
      expect_grant("flush_on_grant", 4'b0000);
      flush = 1'b0;
      cycle("flush_off");
      expect_grant("flush_off_grant", 4'b0010);
      req_valid = '0;
      cycle("flush_idle");
   endtask

   task automatic test_reset_mid();
      load_default_payloads();
      do_reset();
      set_unit(FU_MUL, 6'h2A, 32'hCAFE_F00D);
      req_valid = 4'b0010;
      cycle("mid_grant");
      reset     = 1'b0;
      req_valid = 4'b1111;
      cycle("mid_reset");
      expect_grant("mid_reset_grant", 4'b0000);
      reset = 1'b1;
      cycle("mid_release");
      expect_grant("mid_release_grant", 4'b0001);
      req_valid = '0;
      cycle("mid_idle");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cdb_arbiter
